// File: rtl/vending_engine.sv
// Vending engine: coin credit, item selection, timed dispense, refund.
// Ports: clk, reset (async active-low); coin_5/10/25 pulses; next_item,
// select, cancel button levels; price_wr/price_addr/price_data price
// table write; restock; outputs state, selected_item, total, change,
// dispense, coin_reject, sold_out.
// Optional macro VENDING_STOCK_EN adds per-item stock, restock, sold_out.
module vending_engine #(
    parameter int NUM_ITEMS       = 4,
    parameter int PRICE_W         = 8,
    parameter int STOCK_W         = 4,
    parameter int DISPENSE_CYCLES = 125_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         coin_5,
    input  logic                         coin_10,
    input  logic                         coin_25,
    input  logic                         next_item,
    input  logic                         select,
    input  logic                         cancel,
    input  logic                         price_wr,
    input  logic [$clog2(NUM_ITEMS)-1:0] price_addr,
    input  logic [PRICE_W-1:0]           price_data,
    input  logic                         restock,
    output logic [1:0]                   state,
    output logic [$clog2(NUM_ITEMS)-1:0] selected_item,
    output logic [PRICE_W-1:0]           total,
    output logic [PRICE_W-1:0]           change,
    output logic                         dispense,
    output logic                         coin_reject,
    output logic                         sold_out
);

    localparam int IW = $clog2(NUM_ITEMS);
    localparam int TW = $clog2(DISPENSE_CYCLES + 1);
    // Headroom above PRICE_W so the coin sum cannot wrap.
    localparam int SW = PRICE_W + 7;
    localparam logic [IW-1:0] LAST = IW'(NUM_ITEMS - 1);
    localparam logic [TW-1:0] TLOAD = TW'(DISPENSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        COLLECTING = 2'b01,
        DISPENSING = 2'b10,
        REFUND     = 2'b11
    } st_t;

    st_t                st;
    logic [TW-1:0]      timer;
    logic               next_q;
    logic               select_q;
    logic               cancel_q;
    logic [PRICE_W-1:0] price [NUM_ITEMS];

    logic               next_edge;
    logic               sel_edge;
    logic               can_edge;
    logic [SW-1:0]      coin_val;
    logic [SW-1:0]      sum;
    logic               fits;
    logic               any_coin;
    logic [PRICE_W-1:0] cur_price;
    logic               stock_ok;
    logic               buy;
    logic               quit;
    logic               accept;
    logic               addr_ok;

    assign state     = st;
    assign next_edge = next_item & ~next_q;
    assign sel_edge  = select & ~select_q;
    assign can_edge  = cancel & ~cancel_q;
    assign any_coin  = coin_5 | coin_10 | coin_25;

    always_comb begin
        coin_val = '0;
        if (coin_5)  coin_val = coin_val + SW'(5);
        if (coin_10) coin_val = coin_val + SW'(10);
        if (coin_25) coin_val = coin_val + SW'(25);
    end

    assign sum       = {7'b0, total} + coin_val;
    assign fits      = (sum[SW-1:PRICE_W] == '0);
    assign cur_price = price[selected_item];

    // Cancel wins over select in the same cycle.
    assign quit = (st == COLLECTING) && can_edge;
    assign buy  = (st == COLLECTING) && sel_edge && !can_edge
               && (total >= cur_price) && stock_ok;

    // A coin arriving on the edge credit is taken away is refused.
    assign accept = any_coin && fits
                 && ((st == IDLE)
                     || ((st == COLLECTING) && !buy && !quit));

    generate
        if ((2 ** IW) == NUM_ITEMS) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, price_addr} < (IW + 1)'(NUM_ITEMS));
        end
    endgenerate

`ifdef VENDING_STOCK_EN
    logic [STOCK_W-1:0] stock [NUM_ITEMS];
    assign stock_ok = (stock[selected_item] != '0);
    assign sold_out = (stock[selected_item] == '0);
`else
    logic unused;
    assign unused   = restock;
    assign stock_ok = 1'b1;
    assign sold_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= IDLE;
            total         <= '0;
            change        <= '0;
            selected_item <= '0;
            dispense      <= 1'b0;
            coin_reject   <= 1'b0;
            timer         <= '0;
            next_q        <= 1'b0;
            select_q      <= 1'b0;
            cancel_q      <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price[i] <= PRICE_W'(25 * (i + 1));
`ifdef VENDING_STOCK_EN
                stock[i] <= '1;
`endif
            end
        end else begin
            next_q      <= next_item;
            select_q    <= select;
            cancel_q    <= cancel;
            coin_reject <= any_coin && !accept;

            if (next_edge && (st != DISPENSING)) begin
                selected_item <= (selected_item == LAST)
                               ? '0 : selected_item + IW'(1);
            end

            case (st)
                IDLE: begin
                    if (accept) begin
                        total  <= sum[PRICE_W-1:0];
                        change <= '0;
                        st     <= COLLECTING;
                    end
                end
                COLLECTING: begin
                    if (quit) begin
                        change <= total;
                        total  <= '0;
                        st     <= REFUND;
                    end else if (buy) begin
                        change   <= total - cur_price;
                        total    <= '0;
                        timer    <= TLOAD;
                        dispense <= 1'b1;
                        st       <= DISPENSING;
`ifdef VENDING_STOCK_EN
                        stock[selected_item] <=
                            stock[selected_item] - STOCK_W'(1);
`endif
                    end else if (accept) begin
                        total <= sum[PRICE_W-1:0];
                    end
                end
                DISPENSING: begin
                    if (timer == '0) begin
                        dispense <= 1'b0;
                        st       <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                REFUND: st <= IDLE;
                default: st <= IDLE;
            endcase

            if (price_wr && addr_ok) price[price_addr] <= price_data;
`ifdef VENDING_STOCK_EN
            // Placed after the decrement so restock wins.
            if (restock && addr_ok) stock[price_addr] <= '1;
`endif
        end
    end

endmodule
